// File: rtl/ysyx22040228_fore_ctrl.sv
// Fetch-PC sequencer for the static next-PC predictor: drives fetch, arbitrates the
// shared regfile read port, and queues predictions for execute-time checking.
module ysyx22040228_fore_ctrl #(
    parameter logic [63:0] RESET_PC   = 64'h8000_0000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STARVE_MAX = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] pc_o,
    output logic        pc_valid,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [63:0] pred_pc_i,
    input  logic        pred_x1_ena,
    input  logic [4:0]  pred_x1_addr,
    output logic [63:0] pred_x1_data,
    input  logic [31:0] busy_vec,
    input  logic        dec_rd_req,
    input  logic [4:0]  dec_rd_addr,
    output logic        dec_rd_gnt,
    output logic [4:0]  rf_raddr,
    input  logic [63:0] rf_rdata,
    input  logic        ex_res_valid,
    input  logic [63:0] ex_actual_pc,
    output logic        flush_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        WAIT_RS  = 2'd2,
        REDIRECT = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [63:0]    pc_q, pc_d;
    logic           pc_valid_q, pc_valid_d;
    logic           flush_q, flush_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic [63:0]    fifo_q [FIFO_DEPTH];

    logic [AW-1:0]  rd_idx, wr_idx;
    logic           fifo_empty, fifo_full;
    logic           pop, mispredict, room;
    logic           src_busy, dec_wins, in_run, pred_use, push;

    assign rd_idx     = rd_ptr_q[AW-1:0];
    assign wr_idx     = wr_ptr_q[AW-1:0];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

    // A matching resolve frees the head slot in the same cycle, so a full FIFO may still accept.
    assign pop        = ex_res_valid && !fifo_empty;
    assign mispredict = pop && (fifo_q[rd_idx] != ex_actual_pc);
    assign room       = !fifo_full || (pop && !mispredict);

    assign src_busy   = (pred_x1_addr != 5'd0) && busy_vec[pred_x1_addr];
    assign dec_wins   = dec_rd_req && (starve_q >= SW'(STARVE_MAX));
    assign in_run     = (state_q == RUN);
    assign pred_use   = in_run && inst_valid && pred_x1_ena && !src_busy && room && !dec_wins;

    assign inst_ready   = in_run && room && (!pred_x1_ena || (!src_busy && !dec_wins));
    assign push         = inst_valid && inst_ready && !mispredict;
    assign dec_rd_gnt   = dec_rd_req && !pred_use;
    assign rf_raddr     = pred_use ? pred_x1_addr : dec_rd_addr;
    assign pred_x1_data = (pred_x1_addr == 5'd0) ? 64'd0 : rf_rdata;

    assign pc_o     = pc_q;
    assign pc_valid = pc_valid_q;
    assign flush_o  = flush_q;

    // Next-state, PC, FIFO pointer and starvation logic
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        starve_d = starve_q;
        flush_d  = mispredict;

        unique case (state_q)
            BOOT:     state_d = RUN;
            RUN:      if (inst_valid && pred_x1_ena && src_busy) state_d = WAIT_RS;
            WAIT_RS:  if (!src_busy) state_d = RUN;
            REDIRECT: state_d = RUN;
            default:  state_d = BOOT;
        endcase

        if (mispredict) begin
            state_d  = REDIRECT;
            pc_d     = ex_actual_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                pc_d     = pred_pc_i;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        end

        if (dec_rd_req) begin
            if (dec_rd_gnt)
                starve_d = '0;
            else if (starve_q < SW'(STARVE_MAX))
                starve_d = starve_q + SW'(1);
        end

        pc_valid_d = (state_d == RUN) || (state_d == WAIT_RS);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            flush_q    <= flush_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            starve_q   <= starve_d;
        end
    end

    // Prediction storage; validity is tracked by the pointers alone
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_idx] <= pred_pc_i;
    end

endmodule
